// File: rtl/sp_ram_bist.sv
// sp_ram_bist: March C- self-test initiator for a single-port byte-enable RAM.
// Define SP_RAM_BIST_BE_TEST_EN to append byte-enable element M6 ↑(wP, rE).
module sp_ram_bist #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      fail_o,
  output logic [ADDR_WIDTH-1:0]     fail_addr_o,
  output logic [DATA_WIDTH-1:0]     fail_exp_o,
  output logic [DATA_WIDTH-1:0]     fail_act_o,
  output logic                      ram_en_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  output logic                      ram_we_o,
  output logic [DATA_WIDTH/8-1:0]   ram_be_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

  localparam int BW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

`ifdef SP_RAM_BIST_BE_TEST_EN
  localparam logic [2:0] LAST_ELEM = 3'd6;

  function automatic logic [BW-1:0] even_lanes();
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < BW; i += 2) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] even_bytes();
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < BW; i += 2) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  localparam logic [BW-1:0]         BE_EVEN   = even_lanes();
  localparam logic [DATA_WIDTH-1:0] DATA_EVEN = even_bytes();
`else
  localparam logic [2:0] LAST_ELEM = 3'd5;
`endif

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              elem, seq_elem, op_elem;
  logic                    phase, seq_phase, op_phase;
  logic [ADDR_WIDTH-1:0]   seq_addr, op_addr, cmp_addr;
  logic                    last_op, load, elem_down, elem_pair, at_end;
  logic                    op_we;
  logic [DATA_WIDTH-1:0]   op_wdata, op_exp, cur_exp, cmp_exp;
  logic [BW-1:0]           op_be;
  logic                    cmp_valid, mismatch;

  // Successor of the op currently on the RAM port; ram_addr_o doubles as the address counter.
  always_comb begin
    elem_down = (elem == 3'd3) || (elem == 3'd4);
    elem_pair = (elem != 3'd0) && (elem != 3'd5);
    at_end    = elem_down ? (ram_addr_o == '0) : (ram_addr_o == LAST_ADDR);
    seq_elem  = elem;
    seq_phase = 1'b0;
    seq_addr  = ram_addr_o;
    last_op   = 1'b0;
    if (elem_pair && !phase) begin
      seq_phase = 1'b1;
    end else if (at_end) begin
      if (elem == LAST_ELEM) begin
        last_op = 1'b1;
      end else begin
        seq_elem = elem + 3'd1;
        seq_addr = ((elem == 3'd2) || (elem == 3'd3)) ? LAST_ADDR : '0;
      end
    end else begin
      seq_addr = elem_down ? ram_addr_o - 1'b1 : ram_addr_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (abort_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start_i) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
        RUN:     if (last_op) state_nxt = CHECK;
        CHECK:   state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Decode the op to present next: reads carry the word expected back one cycle later.
  always_comb begin
    op_elem  = load ? 3'd0 : seq_elem;
    op_phase = load ? 1'b0 : seq_phase;
    op_addr  = load ? '0   : seq_addr;
    op_we    = 1'b0;
    op_wdata = '0;
    op_be    = '1;
    op_exp   = '0;
    case (op_elem)
      3'd0: op_we = 1'b1;
      3'd1, 3'd3: begin
        op_we    = op_phase;
        op_wdata = '1;
      end
      3'd2, 3'd4: begin
        op_we  = op_phase;
        op_exp = '1;
      end
`ifdef SP_RAM_BIST_BE_TEST_EN
      3'd6: begin
        op_we    = !op_phase;
        op_wdata = '1;
        op_be    = op_phase ? '1 : BE_EVEN;
        op_exp   = DATA_EVEN;
      end
`endif
      default: op_we = 1'b0;
    endcase
  end

  assign mismatch = cmp_valid && ((state == RUN) || (state == CHECK)) && !abort_i &&
                    (ram_rdata_i != cmp_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_exp_o  <= '0;
      fail_act_o  <= '0;
      ram_en_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      ram_be_o    <= '0;
      elem        <= 3'd0;
      phase       <= 1'b0;
      cur_exp     <= '0;
      cmp_valid   <= 1'b0;
      cmp_exp     <= '0;
      cmp_addr    <= '0;
    end else begin
      busy_o <= (state_nxt == RUN) || (state_nxt == CHECK);
      done_o <= (state_nxt == DONE);
      if (state_nxt == RUN) begin
        ram_en_o    <= 1'b1;
        ram_we_o    <= op_we;
        ram_addr_o  <= op_addr;
        ram_wdata_o <= op_wdata;
        ram_be_o    <= op_be;
        elem        <= op_elem;
        phase       <= op_phase;
        cur_exp     <= op_exp;
      end else begin
        ram_en_o <= 1'b0;
        ram_we_o <= 1'b0;
      end
      cmp_valid <= ram_en_o && !ram_we_o;
      cmp_exp   <= cur_exp;
      cmp_addr  <= ram_addr_o;
      if (load) begin
        fail_o      <= 1'b0;
        fail_addr_o <= '0;
        fail_exp_o  <= '0;
        fail_act_o  <= '0;
      end else if (mismatch && !fail_o) begin
        fail_o      <= 1'b1;
        fail_addr_o <= cmp_addr;
        fail_exp_o  <= cmp_exp;
        fail_act_o  <= ram_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_sp_ram_bist.sv
// tb_sp_ram_bist: directed bench for sp_ram_bist (N=16) with a behavioural RAM.
// Honours SP_RAM_BIST_BE_TEST_EN for the byte-enable element and its timing.
module tb_sp_ram_bist;

  localparam int N = 16;
`ifdef SP_RAM_BIST_BE_TEST_EN
  localparam int TOTAL = 12 * N + 2;
  localparam logic [31:0] FINAL_WORD = 32'h00FF00FF;
`else
  localparam int TOTAL = 10 * N + 2;
  localparam logic [31:0] FINAL_WORD = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, fail_o;
  logic [7:0]  fail_addr_o;
  logic [31:0] fail_exp_o, fail_act_o;
  logic        ram_en_o, ram_we_o;
  logic [7:0]  ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_rdata_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc, en_cnt, busy_cnt;

  logic        stuck_en = 1'b0;
  logic        ignore_be = 1'b0;
  logic [31:0] mem [N];

  logic        tr_en [400];
  logic        tr_we [400];
  logic        tr_busy [400];
  logic        tr_done [400];
  logic [7:0]  tr_addr [400];
  logic [31:0] tr_wdata [400];
  logic [3:0]  tr_be [400];

  sp_ram_bist #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WORDS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .fail_addr_o(fail_addr_o), .fail_exp_o(fail_exp_o), .fail_act_o(fail_act_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM with optional stuck-at-1 on bit 3 of word 5.
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b] || ignore_be)
            mem[ram_addr_o[3:0]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata_i <= mem[ram_addr_o[3:0]] |
                       ((stuck_en && ram_addr_o == 8'd5) ? 32'h8 : 32'h0);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on cycle 0; cycle c is the period after the c-th edge from there.
  task automatic applyStimulus(input int abort_at, input int repulse_at);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    en_cnt = 0;
    busy_cnt = 0;
    while (!done_o && cyc < 400 && !(abort_at != 0 && cyc > abort_at)) begin
      tr_en[cyc] = ram_en_o;   tr_we[cyc] = ram_we_o;     tr_addr[cyc] = ram_addr_o;
      tr_wdata[cyc] = ram_wdata_o; tr_be[cyc] = ram_be_o;
      tr_busy[cyc] = busy_o;   tr_done[cyc] = done_o;
      en_cnt += int'(ram_en_o);
      busy_cnt += int'(busy_o);
      start_i = (cyc == repulse_at);
      abort_i = (cyc == abort_at);
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ctl"}, {59'd0, busy_o, done_o, fail_o, ram_en_o, ram_we_o}, 64'd0);
    checkOutput({tag, "_ram"}, {20'd0, ram_addr_o, ram_wdata_o, ram_be_o}, 64'd0);
    checkOutput({tag, "_faddr"}, {56'd0, fail_addr_o}, 64'd0);
    checkOutput({tag, "_fdata"}, {fail_exp_o, fail_act_o}, 64'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] fault-free run");
    applyStimulus(0, 0);
    checkOutput("ff_done_cycle", 64'(cyc), 64'(TOTAL));
    checkOutput("ff_fail", {63'd0, fail_o}, 64'd0);
    checkOutput("ff_busy_cycles", 64'(busy_cnt), 64'(TOTAL - 1));
    checkOutput("ff_ram_ops", 64'(en_cnt), 64'(TOTAL - 2));
    checkOutput("ff_op1_w0", {tr_en[1], tr_we[1], tr_addr[1], tr_wdata[1], tr_be[1]}, {1'b1, 1'b1, 8'd0, 32'h0, 4'hF});
    checkOutput("ff_op17_r0", {tr_en[17], tr_we[17], tr_addr[17]}, {1'b1, 1'b0, 8'd0});
    checkOutput("ff_op18_w1", {tr_en[18], tr_we[18], tr_addr[18], tr_wdata[18]}, {1'b1, 1'b1, 8'd0, 32'hFFFFFFFF});
    checkOutput("ff_op81_m3_r0", {tr_en[81], tr_we[81], tr_addr[81]}, {1'b1, 1'b0, 8'd15});
    checkOutput("ff_op82_m3_w1", {tr_we[82], tr_addr[82], tr_wdata[82]}, {1'b1, 8'd15, 32'hFFFFFFFF});
    checkOutput("ff_op113_m4_r1", {tr_we[113], tr_addr[113]}, {1'b0, 8'd15});
    checkOutput("ff_op114_m4_w0", {tr_we[114], tr_addr[114], tr_wdata[114]}, {1'b1, 8'd15, 32'h0});
    checkOutput("ff_op145_m5_r0", {tr_en[145], tr_we[145], tr_addr[145]}, {1'b1, 1'b0, 8'd0});
    checkOutput("ff_op160_r", {tr_en[160], tr_we[160], tr_addr[160]}, {1'b1, 1'b0, 8'd15});
`ifdef SP_RAM_BIST_BE_TEST_EN
    checkOutput("ff_op161_wp", {tr_we[161], tr_addr[161], tr_wdata[161], tr_be[161]}, {1'b1, 8'd0, 32'hFFFFFFFF, 4'h5});
`endif
    checkOutput("ff_check_cycle", {62'd0, tr_en[TOTAL-1], tr_busy[TOTAL-1]}, 64'd1);
    checkOutput("ff_done_ctl", {61'd0, busy_o, ram_en_o, ram_we_o}, 64'd0);
    checkOutput("ff_mem7", {32'd0, mem[7]}, {32'd0, FINAL_WORD});

    $display("[TB] stuck-at-1 run, restarted from DONE");
    stuck_en = 1'b1;
    applyStimulus(0, 0);
    checkOutput("sa_restart_c1", {62'd0, tr_done[1], tr_busy[1]}, 64'd1);
    checkOutput("sa_done_cycle", 64'(cyc), 64'(TOTAL));
    checkOutput("sa_fail", {63'd0, fail_o}, 64'd1);
    checkOutput("sa_fail_addr", {56'd0, fail_addr_o}, 64'd5);
    checkOutput("sa_fail_data", {fail_exp_o, fail_act_o}, {32'h0, 32'h8});

    $display("[TB] abort at cycle 40");
    applyStimulus(40, 0);
    checkOutput("ab_c41_ctl", {60'd0, busy_o, done_o, ram_en_o, ram_we_o}, 64'd0);
    checkOutput("ab_fail_kept", {55'd0, fail_o, fail_addr_o}, {55'd0, 1'b1, 8'd5});
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en_cnt += int'(ram_en_o) + int'(busy_o);
    end
    checkOutput("ab_idle_quiet", 64'(en_cnt), 64'd0);

    $display("[TB] clean run with start re-pulsed at cycle 20");
    stuck_en = 1'b0;
    applyStimulus(0, 20);
    checkOutput("rp_done_cycle", 64'(cyc), 64'(TOTAL));
    checkOutput("rp_fail_cleared", {55'd0, fail_o, fail_addr_o}, 64'd0);
    checkOutput("rp_fail_data", {fail_exp_o, fail_act_o}, 64'd0);

    $display("[TB] reset at cycle 70");
    stuck_en = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (69) @(negedge clk);
    checkOutput("rs_pre_fail", {62'd0, fail_o, busy_o}, 64'd3);
    #2 rst_n = 1'b0;
    #1 checkIdleOutputs("rs_async");
    @(negedge clk);
    rst_n = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en_cnt += int'(ram_en_o) + int'(busy_o);
    end
    checkOutput("rs_no_ops", 64'(en_cnt), 64'd0);
    stuck_en = 1'b0;

`ifdef SP_RAM_BIST_BE_TEST_EN
    $display("[TB] byte-enable run with lane gating ignored");
    ignore_be = 1'b1;
    applyStimulus(0, 0);
    checkOutput("be_done_cycle", 64'(cyc), 64'd194);
    checkOutput("be_fail_addr", {55'd0, fail_o, fail_addr_o}, {55'd0, 1'b1, 8'd0});
    checkOutput("be_fail_data", {fail_exp_o, fail_act_o}, {32'h00FF00FF, 32'hFFFFFFFF});
    ignore_be = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sp_ram_bist.md
Name: sp_ram_bist

Overview:
- Memory built-in self-test initiator for the single-port byte-enable RAM (`sp_ram_m32` port set).
- Drives the RAM's en/addr/wdata/we/be inputs and checks rdata using a March C- sequence.
- Sits beside each instruction/data RAM; a RAM-side mux (outside this block) selects BIST or core access.
- Reports pass/fail and captures the first failing address, expected word and actual word.

Parameters:
- ADDR_WIDTH, 8, width of ram_addr_o and fail_addr_o.
- DATA_WIDTH, 32, RAM word width; multiple of 8.
- NUM_WORDS, 256, number of words tested, addresses 0..NUM_WORDS-1; must be ≤ 2**ADDR_WIDTH and ≥ 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  start request; sampled only in IDLE or DONE.
- abort_i  in  1  abandon the test; return to IDLE.
- busy_o  out  1  high while the test is running.
- done_o  out  1  high in DONE; held until the next accepted start.
- fail_o  out  1  sticky; set on the first miscompare.
- fail_addr_o  out  ADDR_WIDTH  address of the first miscompare.
- fail_exp_o  out  DATA_WIDTH  expected word at the first miscompare.
- fail_act_o  out  DATA_WIDTH  actual word at the first miscompare.
- ram_en_o  out  1  RAM enable.
- ram_addr_o  out  ADDR_WIDTH  RAM word address.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables.
- ram_rdata_i  in  DATA_WIDTH  RAM read data; valid one cycle after a read is issued.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state=IDLE.
  - All outputs 0 (busy, done, fail, fail_*, ram_en, ram_we, ram_addr, ram_wdata, ram_be).
- States:
  - IDLE -> RUN on start_i.
  - RUN -> CHECK on issue of the last read.
  - CHECK -> DONE.
  - DONE -> RUN on start_i.
  - Any state -> IDLE on abort_i. abort_i has priority over start_i.
- Start handling:
  - An accepted start clears fail_o and all fail_* outputs, sets busy_o, and loads element M0.
  - start_i while busy is ignored.
- Ops and read compare:
  - One RAM op per cycle in RUN: ram_en_o=1 and ram_be_o all-ones (except the optional element).
  - Read: ram_we_o=0. Its compare happens the next cycle against ram_rdata_i.
  - Write: ram_we_o=1, ram_wdata_o = all-zeros ("0") or all-ones ("1").
- Elements (↑ = address 0 up to N-1, ↓ = N-1 down to 0, N=NUM_WORDS):
  - M0 ↑ w0
  - M1 ↑ (r0,w1)
  - M2 ↑ (r1,w0)
  - M3 ↓ (r0,w1)
  - M4 ↓ (r1,w0)
  - M5 ↑ r0
- Read-then-write pairs use the same address on consecutive cycles. The read of cycle k is compared in cycle k+1, concurrently with the write.
- Address counter:
  - Terminates on explicit compare with 0 or N-1; never relies on wrap.
  - A ↓ element starts at N-1 with no idle cycle between elements.
- CHECK cycle: ram_en_o=0; compares the last read of M5.
- Timing: done_o rises and busy_o falls exactly 10N+2 cycles after the start-accept edge (N=256 gives 2562).
- Fail capture:
  - First miscompare latches fail_addr_o, fail_exp_o and fail_act_o, and sets fail_o.
  - Later miscompares do not overwrite the captured values.
  - The test always runs to completion.
- Abort:
  - ram_en_o and ram_we_o go low on the next edge; busy_o=0, done_o=0.
  - fail_* retain their current values.
- Reset mid-test:
  - Immediate return to reset values.
  - No further RAM ops; a write in flight at the assertion edge is undefined.
- ram_* outputs are registered. In IDLE/DONE: ram_en_o=0, ram_we_o=0.

Optional Feature:
- Macro: SP_RAM_BIST_BE_TEST_EN.
- When defined, element M6 ↑ (wP, rE) is appended after M5:
  - wP: wdata all-ones, ram_be_o = even lanes only (0b0101 for 32-bit).
  - rE: read compared against even bytes 0xFF, odd bytes 0x00 (0x00FF00FF for 32-bit).
  - This verifies byte-enable gating.
  - done_o then rises 12N+2 cycles after start.
- When undefined: no M6; ram_be_o is constant all-ones; timing is 10N+2.

Test Plan:
- Fault-free behavioural RAM, N=16, pulse start_i -> done_o at cycle 162, fail_o=0, busy_o high cycles 1..161, 160 RAM ops with ram_en_o=1.
- RAM with bit 3 of addr 5 stuck-at-1, N=16 -> fail_o=1, fail_addr_o=5, fail_exp_o=0x00000000, fail_act_o=0x00000008; done_o still at cycle 162.
- abort_i asserted at cycle 40 -> ram_en_o=0 and busy_o=0 from cycle 41; state IDLE; a later start_i runs the full 162-cycle test with fail cleared.
- start_i re-pulsed at cycle 20 while busy -> ignored, done_o still at cycle 162; start_i in DONE -> restart, done_o low the next cycle.
- rst_n low asynchronously mid-cycle at cycle 70 -> all outputs 0 immediately, no RAM op until the next start.
- SP_RAM_BIST_BE_TEST_EN defined, RAM model ignoring be_i -> fail_addr_o=0, fail_exp_o=0x00FF00FF, fail_act_o=0xFFFFFFFF, done_o at cycle 194 (N=16).
